// File: rtl/roc_pkg.sv
// Shared definitions for the rank-order-coding encoder/decoder pair.
package roc_pkg;

  localparam int unsigned INDEX_WIDTH = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDX,
    S_CAPTURE,
    S_WRITE,
    S_DONE
  } roc_dec_state_t;

  // Pixel value for a given rank; clamps at zero once rank exceeds max_value.
  function automatic int unsigned rank_to_value(input int unsigned max_value,
                                                input int unsigned rank);
    return (rank > max_value) ? 0 : (max_value - rank);
  endfunction

endpackage

// File: rtl/roc_image_buffer.sv
// Pixel register array plus per-pixel written flags for the ROC decoder.
module roc_image_buffer #(
  parameter int unsigned SIZE      = 7,
  parameter int unsigned ADDR_BITS = 3,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_clear,
  input  logic                            i_we,
  input  logic [ADDR_BITS-1:0]            i_addr,
  input  logic [DATA_BITS-1:0]            i_data,
  output logic                            o_written,
  output logic [SIZE-1:0][DATA_BITS-1:0]  o_image
);

  logic [SIZE-1:0][DATA_BITS-1:0] r_pix;
  logic [SIZE-1:0]                r_written;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pix     <= '0;
      r_written <= '0;
    end else if (i_clear) begin
      r_pix     <= '0;
      r_written <= '0;
    end else if (i_we) begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        if (i_addr == ADDR_BITS'(i)) begin
          r_pix[i]     <= i_data;
          r_written[i] <= 1'b1;
        end
      end
    end
  end

  // Addresses beyond SIZE read back as unwritten.
  always_comb begin
    o_written = 1'b0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (i_addr == ADDR_BITS'(i)) o_written = r_written[i];
    end
  end

  assign o_image = r_pix;

endmodule

// File: rtl/roc_decoder.sv
// Rank-order-coding decoder: rebuilds an image from rank-ordered pixel indices.
module roc_decoder
  import roc_pkg::*;
#(
  parameter int unsigned IMAGE_SIZE      = 7,
  parameter int unsigned IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int unsigned PIXEL_MAX_VALUE = 255,
  parameter int unsigned PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE)
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,
  input  logic                                  START,
  input  logic [INDEX_WIDTH-1:0]                NEXT_INDEX,
  input  logic                                  FOUND_NEXT_INDEX,
  input  logic                                  ENCODER_RDY,
  output logic                                  DECODER_BUSY,
  output logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE,
  output logic                                  IMAGE_VALID,
  output logic [IMAGE_SIZE_BITS:0]              RANK_COUNT,
  output logic                                  ERR_RANGE,
  output logic                                  ERR_DUP,
  output logic                                  ERR_OVF
);

  localparam logic [IMAGE_SIZE_BITS:0] LP_FULL  = (IMAGE_SIZE_BITS+1)'(IMAGE_SIZE);
  localparam logic [IMAGE_SIZE_BITS:0] LP_ONE   = (IMAGE_SIZE_BITS+1)'(1);
  localparam logic [INDEX_WIDTH-1:0]   LP_LIMIT = INDEX_WIDTH'(IMAGE_SIZE);

  roc_dec_state_t           r_state, w_state_next;
  logic [INDEX_WIDTH-1:0]   r_index;
  logic                     r_mark, r_rdy_pend;
  logic [IMAGE_SIZE_BITS:0] r_rank, w_rank_post;
  logic                     r_err_range, r_err_dup, r_err_ovf;
  logic                     w_busy, w_in_range, w_written, w_we;
  logic [PIXEL_BITS-1:0]    w_wdata;

  assign w_busy      = (r_state == S_CAPTURE) || (r_state == S_WRITE);
  assign w_in_range  = (r_index < LP_LIMIT);
  assign w_we        = (r_state == S_WRITE) && r_mark && !START;
  assign w_wdata     = PIXEL_BITS'(rank_to_value(PIXEL_MAX_VALUE, 32'(r_rank)));
  assign w_rank_post = r_mark ? (r_rank + LP_ONE) : r_rank;

  roc_image_buffer #(
    .SIZE      (IMAGE_SIZE),
    .ADDR_BITS (IMAGE_SIZE_BITS),
    .DATA_BITS (PIXEL_BITS)
  ) u_buf (
    .i_clk     (CLK),
    .i_rst_n   (RST_N),
    .i_clear   (START),
    .i_we      (w_we),
    .i_addr    (r_index[IMAGE_SIZE_BITS-1:0]),
    .i_data    (w_wdata),
    .o_written (w_written),
    .o_image   (IMAGE)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (START) begin
      w_state_next = S_WAIT_IDX;
    end else begin
      case (r_state)
        S_IDLE:     w_state_next = S_IDLE;
        S_WAIT_IDX: begin
          if (FOUND_NEXT_INDEX) w_state_next = S_CAPTURE;
          else if (ENCODER_RDY) w_state_next = S_DONE;
        end
        S_CAPTURE:  w_state_next = S_WRITE;
        // An encoder-ready seen during the handshake ends the image once the in-flight index lands.
        S_WRITE: begin
          if (w_rank_post == LP_FULL || r_rdy_pend || ENCODER_RDY) w_state_next = S_DONE;
          else                                                      w_state_next = S_WAIT_IDX;
        end
        S_DONE:     w_state_next = S_DONE;
        default:    w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_index     <= '0;
      r_mark      <= 1'b0;
      r_rdy_pend  <= 1'b0;
      r_rank      <= '0;
      r_err_range <= 1'b0;
      r_err_dup   <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else if (START) begin
      r_mark      <= 1'b0;
      r_rdy_pend  <= 1'b0;
      r_rank      <= '0;
      r_err_range <= 1'b0;
      r_err_dup   <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT_IDX: begin
          if (FOUND_NEXT_INDEX) begin
            r_index    <= NEXT_INDEX;
            r_rdy_pend <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (!w_in_range) begin
            r_err_range <= 1'b1;
            r_mark      <= 1'b0;
          end else if (w_written) begin
            r_err_dup <= 1'b1;
            r_mark    <= 1'b0;
          end else begin
            r_mark <= 1'b1;
          end
          if (FOUND_NEXT_INDEX) r_err_ovf  <= 1'b1;
          if (ENCODER_RDY)      r_rdy_pend <= 1'b1;
        end
        S_WRITE: begin
          r_rank     <= w_rank_post;
          r_mark     <= 1'b0;
          r_rdy_pend <= 1'b0;
          if (FOUND_NEXT_INDEX) r_err_ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign DECODER_BUSY = w_busy;
  assign IMAGE_VALID  = (r_state == S_DONE);
  assign RANK_COUNT   = r_rank;
  assign ERR_RANGE    = r_err_range;
  assign ERR_DUP      = r_err_dup;
  assign ERR_OVF      = r_err_ovf;

endmodule

// File: tb/tb_roc_decoder.sv
// Directed self-checking bench for roc_decoder with hand-computed expectations.
module tb_roc_decoder;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            START = 1'b0;
  logic [9:0]      NEXT_INDEX = '0;
  logic            FOUND_NEXT_INDEX = 1'b0;
  logic            ENCODER_RDY = 1'b0;
  logic            DECODER_BUSY;
  logic [6:0][7:0] IMAGE;
  logic            IMAGE_VALID;
  logic [3:0]      RANK_COUNT;
  logic            ERR_RANGE, ERR_DUP, ERR_OVF;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned seq      [7] = '{3, 0, 6, 1, 5, 2, 4};
  int unsigned exp_full [7] = '{254, 252, 250, 255, 249, 251, 253};

  roc_decoder dut (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .START            (START),
    .NEXT_INDEX       (NEXT_INDEX),
    .FOUND_NEXT_INDEX (FOUND_NEXT_INDEX),
    .ENCODER_RDY      (ENCODER_RDY),
    .DECODER_BUSY     (DECODER_BUSY),
    .IMAGE            (IMAGE),
    .IMAGE_VALID      (IMAGE_VALID),
    .RANK_COUNT       (RANK_COUNT),
    .ERR_RANGE        (ERR_RANGE),
    .ERR_DUP          (ERR_DUP),
    .ERR_OVF          (ERR_OVF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic send_idx(input int unsigned idx);
    NEXT_INDEX       = idx[9:0];
    FOUND_NEXT_INDEX = 1'b1;
    tick();
    FOUND_NEXT_INDEX = 1'b0;
    tick();
    tick();
  endtask

  task automatic full_image(input string tag);
    for (int i = 0; i < 7; i++) send_idx(seq[i]);
    check({tag, "_valid"}, IMAGE_VALID, 1);
    check({tag, "_busy"},  DECODER_BUSY, 0);
    check({tag, "_rank"},  RANK_COUNT, 7);
    check({tag, "_errs"},  {ERR_RANGE, ERR_DUP, ERR_OVF}, 0);
    for (int i = 0; i < 7; i++) check($sformatf("%s_px%0d", tag, i), IMAGE[i], exp_full[i]);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_busy",  DECODER_BUSY, 0);
    check("rst_valid", IMAGE_VALID, 0);
    check("rst_rank",  RANK_COUNT, 0);
    check("rst_errs",  {ERR_RANGE, ERR_DUP, ERR_OVF}, 0);
    for (int i = 0; i < 7; i++) check($sformatf("rst_px%0d", i), IMAGE[i], 0);
    RST_N = 1'b1;
    tick();

    // Full image
    pulse_start();
    check("start_valid", IMAGE_VALID, 0);
    full_image("full");
    send_idx(1);
    check("done_ign_ovf", ERR_OVF, 0);
    check("done_ign_dup", ERR_DUP, 0);
    check("done_ign_px1", IMAGE[1], 252);
    check("done_ign_rank", RANK_COUNT, 7);

    // BUSY timing and overflow
    pulse_start();
    check("bt_busy_T", DECODER_BUSY, 0);
    check("bt_clear_px3", IMAGE[3], 0);
    NEXT_INDEX = 10'd5;
    FOUND_NEXT_INDEX = 1'b1;
    tick();
    check("bt_busy_T1", DECODER_BUSY, 1);
    NEXT_INDEX = 10'd2;
    tick();
    FOUND_NEXT_INDEX = 1'b0;
    check("bt_busy_T2", DECODER_BUSY, 1);
    check("bt_ovf", ERR_OVF, 1);
    check("bt_px5_early", IMAGE[5], 0);
    tick();
    check("bt_busy_T3", DECODER_BUSY, 0);
    check("bt_px5", IMAGE[5], 255);
    check("bt_px2", IMAGE[2], 0);
    check("bt_rank", RANK_COUNT, 1);

    // Range / duplicate
    pulse_start();
    check("rd_ovf_clr", ERR_OVF, 0);
    send_idx(2);
    send_idx(9);
    check("rd_range", ERR_RANGE, 1);
    send_idx(2);
    send_idx(0);
    check("rd_range_hold", ERR_RANGE, 1);
    check("rd_dup", ERR_DUP, 1);
    check("rd_ovf", ERR_OVF, 0);
    check("rd_px2", IMAGE[2], 255);
    check("rd_px0", IMAGE[0], 254);
    check("rd_rank", RANK_COUNT, 2);
    check("rd_valid", IMAGE_VALID, 0);

    // Early end
    pulse_start();
    send_idx(4);
    send_idx(1);
    ENCODER_RDY = 1'b1;
    tick();
    ENCODER_RDY = 1'b0;
    check("ee_valid", IMAGE_VALID, 1);
    check("ee_px4", IMAGE[4], 255);
    check("ee_px1", IMAGE[1], 254);
    check("ee_rank", RANK_COUNT, 2);
    for (int i = 0; i < 7; i++)
      if (i != 4 && i != 1) check($sformatf("ee_zero_px%0d", i), IMAGE[i], 0);

    // Encoder ready while busy
    pulse_start();
    NEXT_INDEX = 10'd3;
    FOUND_NEXT_INDEX = 1'b1;
    tick();
    FOUND_NEXT_INDEX = 1'b0;
    ENCODER_RDY = 1'b1;
    tick();
    ENCODER_RDY = 1'b0;
    check("rb_busy", DECODER_BUSY, 1);
    tick();
    check("rb_valid", IMAGE_VALID, 1);
    check("rb_px3", IMAGE[3], 255);
    check("rb_rank", RANK_COUNT, 1);

    // Async reset mid-CAPTURE
    pulse_start();
    send_idx(0);
    NEXT_INDEX = 10'd1;
    FOUND_NEXT_INDEX = 1'b1;
    tick();
    FOUND_NEXT_INDEX = 1'b0;
    check("ar_busy_pre", DECODER_BUSY, 1);
    #2 RST_N = 1'b0;
    #1;
    check("ar_busy", DECODER_BUSY, 0);
    check("ar_rank", RANK_COUNT, 0);
    check("ar_px0", IMAGE[0], 0);
    check("ar_valid", IMAGE_VALID, 0);
    tick();
    RST_N = 1'b1;
    tick();

    // START during WRITE
    pulse_start();
    send_idx(0);
    send_idx(8);
    NEXT_INDEX = 10'd1;
    FOUND_NEXT_INDEX = 1'b1;
    tick();
    FOUND_NEXT_INDEX = 1'b0;
    tick();
    check("sw_in_write", DECODER_BUSY, 1);
    pulse_start();
    check("sw_busy", DECODER_BUSY, 0);
    check("sw_rank", RANK_COUNT, 0);
    check("sw_px0", IMAGE[0], 0);
    check("sw_px1", IMAGE[1], 0);
    check("sw_range", ERR_RANGE, 0);
    full_image("restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/roc_decoder.md
# roc_decoder

Rank-order-coding decoder: the receiving end of the ROC encoder's index stream. It consumes pixel indices delivered in rank order (brightest first) over the 10-bit AER-style index link with a BUSY back-pressure handshake. It rebuilds an IMAGE_SIZE-pixel image in which each pixel's value encodes its rank. It sits between the AER input link and the host/readback logic and is used for loopback checking of the encoder and for host-side reconstruction.

## Interface
- IMAGE_SIZE, 7: number of pixels per image
- IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE): rank counter / pixel address width
- PIXEL_MAX_VALUE, 255: value assigned to rank 0
- PIXEL_BITS, $clog2(PIXEL_MAX_VALUE): pixel width (8 at default)

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- START  in  1  one-cycle pulse: clear buffer, begin new image
- NEXT_INDEX  in  10  pixel index, valid with FOUND_NEXT_INDEX
- FOUND_NEXT_INDEX  in  1  one-cycle pulse: NEXT_INDEX valid
- ENCODER_RDY  in  1  level: encoder finished; forces completion
- DECODER_BUSY  out  1  back-pressure; producer holds off while high
- IMAGE  out  [PIXEL_BITS-1:0] x IMAGE_SIZE  decoded image
- IMAGE_VALID  out  1  level: image complete, IMAGE stable
- RANK_COUNT  out  IMAGE_SIZE_BITS+1  indices accepted so far
- ERR_RANGE  out  1  sticky: index >= IMAGE_SIZE received
- ERR_DUP  out  1  sticky: index received twice in one image
- ERR_OVF  out  1  sticky: FOUND_NEXT_INDEX while DECODER_BUSY high

## Operation
- States: IDLE, WAIT_IDX, CAPTURE, WRITE, DONE.
- IDLE: waits for START. START → clear every pixel to 0, clear written-bit vector, RANK_COUNT, and all ERR_*. Go to WAIT_IDX.
- WAIT_IDX: FOUND_NEXT_INDEX=1 → latch NEXT_INDEX and raise DECODER_BUSY. Go to CAPTURE.
- WAIT_IDX: ENCODER_RDY=1 with no pulse → DONE. Unreceived pixels stay 0.
- CAPTURE:
  - index >= IMAGE_SIZE → set ERR_RANGE; the event is dropped.
  - written[index]=1 → set ERR_DUP; the event is dropped.
  - Otherwise the event is marked for write.
  - Always go to WRITE.
- WRITE, when marked:
  - IMAGE[index] = PIXEL_MAX_VALUE − RANK_COUNT, saturating at 0 when RANK_COUNT > PIXEL_MAX_VALUE.
  - Set written[index]; RANK_COUNT += 1.
- WRITE exit: drop DECODER_BUSY. Go to DONE if RANK_COUNT (post-increment) == IMAGE_SIZE, else WAIT_IDX.
- DONE: IMAGE_VALID=1, IMAGE frozen. START → clear and go to WAIT_IDX. FOUND_NEXT_INDEX in DONE is ignored, no error.
- Rank arithmetic is unsigned, width IMAGE_SIZE_BITS+1. Subtraction is done at PIXEL_BITS+1 and clamped.
- START in any state, including mid-handshake: takes priority over every other input. It performs the clear, goes to WAIT_IDX, and drops DECODER_BUSY on the next cycle.
- FOUND_NEXT_INDEX while DECODER_BUSY=1 (CAPTURE/WRITE): the index is discarded and ERR_OVF is set.
- ENCODER_RDY while BUSY: the in-flight index completes first, then the FSM goes to DONE.

## Timing
- Reset: state=IDLE; DECODER_BUSY=0, IMAGE_VALID=0, RANK_COUNT=0, ERR_*=0; all IMAGE pixels 0.
- FOUND_NEXT_INDEX sampled at edge T → DECODER_BUSY=1 from T+1 through T+2; 0 at T+3.
- Pixel written at edge T+2 (visible T+3). Earliest next accepted pulse is at T+3, so sustained rate is one index per 3 cycles.
- IMAGE_VALID rises the cycle after the last WRITE, so it coincides with BUSY falling. It stays high until START or reset.
- Error flags assert one cycle after the CAPTURE edge and hold until START or reset.

## Structure
- Shared package roc_pkg:
  - state enum roc_dec_state_t
  - INDEX_WIDTH=10 (shared with the encoder)
  - rank-to-value function, saturating
- Sub-module roc_image_buffer holds the IMAGE_SIZE x PIXEL_BITS register array plus the written-bit vector.
  - Ports: clear, write enable, address, data; per-address written flag out.
  - Same asynchronous active-low reset.
- FSM, rank counter and error logic stay in roc_decoder.

## Test plan
- Full image: START, then indices 3,0,6,1,5,2,4 one per 3+ cycles.
  - IMAGE = {254,252,250,255,249,251,253} (index 0..6).
  - IMAGE_VALID=1 after the 7th; RANK_COUNT=7; no errors.
- BUSY timing: single pulse at edge T.
  - DECODER_BUSY=1 exactly at T+1, T+2; pixel visible at T+3.
  - Pulse at T+1 sets ERR_OVF, and that index is not written.
- Range/duplicate: indices 2, 9, 2, 0.
  - ERR_RANGE=1 and ERR_DUP=1.
  - IMAGE[2]=255, IMAGE[0]=254; RANK_COUNT=2.
- Early end: indices 4,1, then ENCODER_RDY=1.
  - IMAGE_VALID=1; IMAGE[4]=255, IMAGE[1]=254; others 0.
- Reset/restart:
  - RST_N low mid-CAPTURE → all outputs reset values within the same cycle (async).
  - START during WRITE → buffer cleared, RANK_COUNT=0, BUSY=0 next cycle.
  - Then a full sequence decodes correctly.
